// File: rtl/fifo_flops.sv
// fifo_flops: single-clock flop-based first-word-fall-through FIFO with registered occupancy count.
module fifo_flops #(
  parameter int bits  = 32,
  parameter int depth = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] Din,
  input  logic            push,
  input  logic            pop,
  output logic [bits-1:0] Dout,
  output logic            full,
  output logic            pndng
);
  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth) + 1;
  logic [bits-1:0] mem [depth];
  logic [pw-1:0]   wr_ptr, rd_ptr;
  logic [cw-1:0]   count;
  logic            do_push, do_pop;
  assign full    = count == cw'(depth);
  assign pndng   = count != '0;
  assign do_pop  = pop && pndng;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push && (!full || do_pop);
  assign Dout    = pndng ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= Din;
        wr_ptr      <= (wr_ptr == pw'(depth - 1)) ? '0 : wr_ptr + pw'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == pw'(depth - 1)) ? '0 : rd_ptr + pw'(1);
      count <= count + cw'(do_push) - cw'(do_pop);
    end
  end
endmodule

// File: tb/tb_fifo_flops.sv
// tb_fifo_flops: directed and randomized checks of fifo_flops against a queue-based model.
module tb_fifo_flops;
  localparam int BITS  = 32;
  localparam int DEPTH = 16;
  logic            clk = 0;
  logic            rst = 1;
  logic [BITS-1:0] din = '0;
  logic [BITS-1:0] dout;
  logic            push = 0, pop = 0, full, pndng;
  int              checks = 0, failures = 0;
  logic [BITS-1:0] model [$];

  always #5 clk = ~clk;

  fifo_flops #(.bits(BITS), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop),
    .Dout(dout), .full(full), .pndng(pndng)
  );

  function automatic logic [BITS-1:0] head();
    return model.size() > 0 ? model[0] : '0;
  endfunction

  // one clock: drive inputs, advance the model by the queue rules, settle 1 time unit past the edge
  task automatic step(input logic p, input logic q, input logic [BITS-1:0] d);
    bit po, pu;
    push = p; pop = q; din = d;
    @(posedge clk);
    po = q && model.size() > 0;
    pu = p && (model.size() < DEPTH || po);
    if (po) void'(model.pop_front());
    if (pu) model.push_back(d);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      push = 1'($urandom); pop = 1'($urandom); din = $urandom;
      @(posedge clk); #1;
      checks += 4;
      if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%0h exp=0", dout); end
      if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      if (pndng !== 1'b0) begin failures++; $display("FAIL reset_pndng got=%b exp=0", pndng); end
      if (dut.count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.count); end
    end
    push = 0; pop = 0;
    @(negedge clk) rst = 1;
    model.delete();
    @(posedge clk); #1;
    checks += 2;
    if (pndng !== 1'b0) begin failures++; $display("FAIL release_pndng got=%b exp=0", pndng); end
    if (dut.count !== '0) begin failures++; $display("FAIL release_count got=%0d exp=0", dut.count); end
  endtask

  task automatic test_single();
    step(1, 0, 32'h5);
    checks += 3;
    if (pndng !== 1'b1) begin failures++; $display("FAIL single_pndng got=%b exp=1", pndng); end
    if (dut.count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", dut.count); end
    if (dout !== 32'h5) begin failures++; $display("FAIL single_dout got=%0h exp=5", dout); end
    step(0, 1, '0);
    checks += 3;
    if (pndng !== 1'b0) begin failures++; $display("FAIL single_pop_pndng got=%b exp=0", pndng); end
    if (dut.count !== '0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", dut.count); end
    if (dout !== '0) begin failures++; $display("FAIL single_pop_dout got=%0h exp=0", dout); end
    step(0, 1, '0);
    checks += 2;
    if (dout !== '0) begin failures++; $display("FAIL empty_pop_dout got=%0h exp=0", dout); end
    if (dut.count !== '0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", dut.count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, BITS'(i));
      checks++;
      if (full !== (i == DEPTH - 1)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == DEPTH - 1); end
    end
    checks++;
    if (dut.count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", dut.count); end
    step(1, 0, 32'd99);
    checks += 3;
    if (dut.count !== 5'd16) begin failures++; $display("FAIL drop_count got=%0d exp=16", dut.count); end
    if (full !== 1'b1) begin failures++; $display("FAIL drop_full got=%b exp=1", full); end
    if (dout !== 32'd0) begin failures++; $display("FAIL drop_dout got=%0h exp=0", dout); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dout !== BITS'(i)) begin failures++; $display("FAIL drain_dout[%0d] got=%0h exp=%0h", i, dout, i); end
      step(0, 1, '0);
    end
    checks += 2;
    if (pndng !== 1'b0) begin failures++; $display("FAIL drain_pndng got=%b exp=0", pndng); end
    if (full !== 1'b0) begin failures++; $display("FAIL drain_full got=%b exp=0", full); end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 32'd7); step(1, 0, 32'd8); step(1, 0, 32'd9);
    step(1, 1, 32'd10);
    checks += 2;
    if (dut.count !== 5'd3) begin failures++; $display("FAIL simul_count got=%0d exp=3", dut.count); end
    if (dout !== 32'd8) begin failures++; $display("FAIL simul_dout got=%0h exp=8", dout); end
    for (int i = 0; i < DEPTH - 3; i++) step(1, 0, BITS'(200 + i));
    step(1, 1, 32'd77);
    checks += 3;
    if (full !== 1'b1) begin failures++; $display("FAIL simul_full got=%b exp=1", full); end
    if (dout !== 32'd9) begin failures++; $display("FAIL simul_full_dout got=%0h exp=9", dout); end
    if (model[DEPTH-1] !== 32'd77) begin failures++; $display("FAIL simul_model_tail got=%0h exp=77", model[DEPTH-1]); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dout !== head()) begin failures++; $display("FAIL simul_drain[%0d] got=%0h exp=%0h", i, dout, head()); end
      step(0, 1, '0);
    end
    checks++;
    if (pndng !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b exp=0", pndng); end
    step(1, 1, 32'd55);
    checks += 2;
    if (dut.count !== 5'd1) begin failures++; $display("FAIL empty_pushpop_count got=%0d exp=1", dut.count); end
    if (dout !== 32'd55) begin failures++; $display("FAIL empty_pushpop_dout got=%0h exp=55", dout); end
    step(0, 1, '0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1, 0, BITS'(i));
    for (int i = 0; i < 10; i++) step(0, 1, '0);
    for (int i = 0; i < 12; i++) step(1, 0, BITS'(100 + i));
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (dout !== BITS'(100 + i)) begin failures++; $display("FAIL wrap_dout[%0d] got=%0h exp=%0h", i, dout, 100 + i); end
      step(0, 1, '0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 0, BITS'(40 + i));
    checks++;
    if (dut.count !== 5'd5) begin failures++; $display("FAIL mid_pre_count got=%0d exp=5", dut.count); end
    push = 0; pop = 0;
    #2 rst = 0;
    #1;
    model.delete();
    checks += 4;
    if (dout !== '0) begin failures++; $display("FAIL mid_dout got=%0h exp=0", dout); end
    if (pndng !== 1'b0) begin failures++; $display("FAIL mid_pndng got=%b exp=0", pndng); end
    if (full !== 1'b0) begin failures++; $display("FAIL mid_full got=%b exp=0", full); end
    if (dut.count !== '0) begin failures++; $display("FAIL mid_count got=%0d exp=0", dut.count); end
    #3 rst = 1;
    step(1, 0, 32'hA);
    checks += 2;
    if (dout !== 32'hA) begin failures++; $display("FAIL mid_after_dout got=%0h exp=a", dout); end
    if (dut.count !== 5'd1) begin failures++; $display("FAIL mid_after_count got=%0d exp=1", dut.count); end
    step(0, 1, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45), $urandom);
      checks += 4;
      if (dout !== head()) begin failures++; $display("FAIL rand_dout[%0d] got=%0h exp=%0h", i, dout, head()); end
      if (int'(dut.count) !== model.size()) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, dut.count, model.size()); end
      if (full !== (model.size() == DEPTH)) begin failures++; $display("FAIL rand_full[%0d] got=%b exp=%b", i, full, model.size() == DEPTH); end
      if (pndng !== (model.size() != 0)) begin failures++; $display("FAIL rand_pndng[%0d] got=%b exp=%b", i, pndng, model.size() != 0); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
